exe_mem_stage_buffer: RTL and testbench
=======================================

// Module: exe_mem_stage_buffer
// PURPOSE
//   Parametrised EXE->MEM pipeline boundary carrying PC, ALU result, store value,
//   destination register and MEM/WB control. Adds valid/ready flow control,
//   optional 2-entry skid buffering, synchronous flush (bubble insertion),
//   a forwarding tap for the hazard unit and a saturating back-pressure counter.
// PARAMETERS
//   XLEN     32  width of pc, alu_result, st_val, fwd_value
//   REG_AW    5  width of dest / fwd_dest
//   SKID_EN   1  1 = 2-entry skid buffer, registered in_ready; 0 = single register
//   CNT_W    16  width of stall_cycles
// PORTS
//   clk            in   1       clock, rising edge
//   rst            in   1       reset, asynchronous, active-high
//   flush          in   1       synchronous kill of all held entries
//   in_valid       in   1       upstream (EXE) bundle valid
//   in_ready       out  1       stage can accept a bundle this cycle
//   in_pc/in_alu_result/in_st_val  in  XLEN  payload from EXE
//   in_dest        in   REG_AW  destination register index
//   in_mem_r_en/in_mem_w_en/in_wb_en  in  1  control bits
//   out_valid      out  1       head bundle valid toward MEM
//   out_ready      in   1       MEM consumes head this cycle
//   out_pc/out_alu_result/out_st_val  out  XLEN  head payload
//   out_dest       out  REG_AW  head destination
//   out_mem_r_en/out_mem_w_en/out_wb_en  out  1  head control
//   fwd_valid      out  1       out_valid & out_wb_en & ~out_mem_r_en
//   fwd_dest       out  REG_AW  = out_dest
//   fwd_value      out  XLEN    = out_alu_result
//   occupancy      out  2       held entries, 0..2 (max 1 when SKID_EN=0)
//   stall_cycles   out  CNT_W   cycles with out_valid & ~out_ready, saturating
// BEHAVIOUR
//   Reset: all out_* / fwd_* / occupancy / stall_cycles = 0; out_valid=0;
//     in_ready=1. Reset mid-transfer discards all held entries.
//   Transfers: accept = in_valid & in_ready; pop = out_valid & out_ready.
//   Control bits of an invalid entry are forced 0, so out_mem_r_en/w_en/wb_en=0
//     whenever out_valid=0; payload fields of invalid entries are don't-care.
//   SKID_EN=0: in_ready = ~out_valid | out_ready (combinational). On accept,
//     head loads input next edge; on pop without accept, out_valid->0. Latency 1.
//   SKID_EN=1: entries HEAD (drives out_*) and SKID. in_ready = ~skid_valid,
//     registered (no comb path out_ready->in_ready). Per edge:
//     - head empty or pop: HEAD <= SKID if skid_valid (SKID clears), else input
//       if accept, else HEAD invalid.
//     - head full, no pop, accept: SKID <= input.
//     - pop and accept with skid_valid: impossible (in_ready=0).
//     Ordering strictly FIFO; full throughput, no bubbles while out_ready=1.
//     Latency input->out_valid: 1 cycle when empty.
//   Occupancy states: EMPTY(0) -> ONE(1) on accept; ONE->TWO on accept&~pop;
//     TWO->ONE on pop; ONE->EMPTY on pop&~accept; ONE stays on accept&pop.
//   flush (priority over everything except rst): next edge all entries invalid,
//     occupancy=0; bundle accepted in the flush cycle is dropped; pop in flush
//     cycle still counts as consumed by MEM. in_ready=1 the cycle after flush.
//   stall_cycles: +1 each edge with out_valid & ~out_ready; holds at 2^CNT_W-1;
//     cleared only by rst (not by flush).
//   fwd_*: purely combinational from head; no stale forward after flush.
// TESTING
//   1. Reset, then in_valid=1 pc=0x100 alu=0x5 dest=3 wb=1, out_ready=1 ->
//      next cycle out_valid=1, out_pc=0x100, fwd_valid=1, fwd_dest=3, fwd_value=5.
//   2. SKID_EN=1, out_ready=0, push A,B -> occupancy=2, in_ready=0, out_pc=A;
//      raise out_ready -> A then B popped in order, in_ready=1 after B moves up.
//   3. Stream 8 bundles with out_ready=1 both modes -> 8 pops in 8 consecutive
//      cycles, no bubbles, stall_cycles stays 0.
//   4. Occupancy 2, assert flush with in_valid=1 -> next cycle out_valid=0,
//      occupancy=0, all control outs 0, flushed-cycle input never appears.
//   5. CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cycles=15 held.
//   6. Load with mem_r_en=1 wb_en=1 -> fwd_valid=0; async rst mid-stall ->
//      all outputs 0 immediately, in_ready=1.

Source files
------------

// File: rtl/exe_mem_stage_buffer.sv
// EXE->MEM pipeline boundary with valid/ready flow control, optional 2-entry skid
// buffer, synchronous flush, hazard-unit forwarding tap and a saturating stall counter.
module exe_mem_stage_buffer #(
  parameter int XLEN    = 32,
  parameter int REG_AW  = 5,
  parameter int SKID_EN = 1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_alu_result,
  input  logic [XLEN-1:0]   in_st_val,
  input  logic [REG_AW-1:0] in_dest,
  input  logic              in_mem_r_en,
  input  logic              in_mem_w_en,
  input  logic              in_wb_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [XLEN-1:0]   out_alu_result,
  output logic [XLEN-1:0]   out_st_val,
  output logic [REG_AW-1:0] out_dest,
  output logic              out_mem_r_en,
  output logic              out_mem_w_en,
  output logic              out_wb_en,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_dest,
  output logic [XLEN-1:0]   fwd_value,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cycles
);

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   alu_result;
    logic [XLEN-1:0]   st_val;
    logic [REG_AW-1:0] dest;
    logic              mem_r_en;
    logic              mem_w_en;
    logic              wb_en;
  } entry_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  entry_t           head_q, head_d, skid_q, skid_d, in_entry;
  logic             head_valid_q, head_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             accept, pop;

  always_comb begin
    in_entry.pc         = in_pc;
    in_entry.alu_result = in_alu_result;
    in_entry.st_val     = in_st_val;
    in_entry.dest       = in_dest;
    in_entry.mem_r_en   = in_mem_r_en;
    in_entry.mem_w_en   = in_mem_w_en;
    in_entry.wb_en      = in_wb_en;
  end

  // With the skid buffer, in_ready comes straight from a flop so out_ready never reaches it.
  assign in_ready = (SKID_EN != 0) ? ~skid_valid_q : (~head_valid_q | out_ready);
  assign accept   = in_valid & in_ready;
  assign pop      = head_valid_q & out_ready;

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the ifs infers a latch.
    head_d       = head_q;
    head_valid_d = head_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      head_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (SKID_EN != 0) begin
      if (!head_valid_q || pop) begin
        if (skid_valid_q) begin
          head_d       = skid_q;
          head_valid_d = 1'b1;
          skid_valid_d = 1'b0;
        end else if (accept) begin
          head_d       = in_entry;
          head_valid_d = 1'b1;
        end else begin
          head_valid_d = 1'b0;
        end
      end else if (accept) begin
        skid_d       = in_entry;
        skid_valid_d = 1'b1;
      end
    end else begin
      if (accept) begin
        head_d       = in_entry;
        head_valid_d = 1'b1;
      end else if (pop) begin
        head_valid_d = 1'b0;
      end
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (head_valid_q && !out_ready && stall_q != CNT_MAX) stall_d = stall_q + CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: payload flops are reset too, because out_* must read zero straight out of reset.
      head_q       <= '0;
      skid_q       <= '0;
      head_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      stall_q      <= '0;
    end else begin
      head_q       <= head_d;
      skid_q       <= skid_d;
      head_valid_q <= head_valid_d;
      skid_valid_q <= skid_valid_d;
      stall_q      <= stall_d;
    end
  end

  assign out_valid      = head_valid_q;
  assign out_pc         = head_q.pc;
  assign out_alu_result = head_q.alu_result;
  assign out_st_val     = head_q.st_val;
  assign out_dest       = head_q.dest;
  assign out_mem_r_en   = head_valid_q & head_q.mem_r_en;
  assign out_mem_w_en   = head_valid_q & head_q.mem_w_en;
  assign out_wb_en      = head_valid_q & head_q.wb_en;

  // Loads are not forwardable from this stage: their data only exists after MEM.
  assign fwd_valid      = out_valid & out_wb_en & ~out_mem_r_en;
  assign fwd_dest       = out_dest;
  assign fwd_value      = out_alu_result;

  assign occupancy      = {1'b0, head_valid_q} + {1'b0, skid_valid_q};
  assign stall_cycles   = stall_q;

endmodule

// File: tb/tb_exe_mem_stage_buffer.sv
// Bench for exe_mem_stage_buffer: skid (CNT_W=4) and single-register instances share
// stimulus; a queue model per instance predicts every output.
module tb_exe_mem_stage_buffer;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] st;
    logic [4:0]  dest;
    logic        r;
    logic        w;
    logic        wb;
  } ent_t;

  typedef struct {
    bit   in_valid;
    ent_t e;
    bit   out_ready;
    bit   flush;
    int   exp_occ_a;
    bit   exp_rdy_a;
    int   exp_occ_b;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_pc = '0, in_alu_result = '0, in_st_val = '0;
  logic [4:0]  in_dest = '0;
  logic        in_mem_r_en = 1'b0, in_mem_w_en = 1'b0, in_wb_en = 1'b0;

  logic        in_ready_a, out_valid_a, r_a, w_a, wb_a, fv_a;
  logic [31:0] pc_a, alu_a, st_a, fval_a;
  logic [4:0]  dest_a, fd_a;
  logic [1:0]  occ_a;
  logic [3:0]  sc_a;

  logic        in_ready_b, out_valid_b, r_b, w_b, wb_b, fv_b;
  logic [31:0] pc_b, alu_b, st_b, fval_b;
  logic [4:0]  dest_b, fd_b;
  logic [1:0]  occ_b;
  logic [15:0] sc_b;

  always #5 clk = ~clk;

  exe_mem_stage_buffer #(.XLEN(32), .REG_AW(5), .SKID_EN(1), .CNT_W(4)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_pc(in_pc), .in_alu_result(in_alu_result), .in_st_val(in_st_val), .in_dest(in_dest),
    .in_mem_r_en(in_mem_r_en), .in_mem_w_en(in_mem_w_en), .in_wb_en(in_wb_en),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_pc(pc_a), .out_alu_result(alu_a),
    .out_st_val(st_a), .out_dest(dest_a), .out_mem_r_en(r_a), .out_mem_w_en(w_a),
    .out_wb_en(wb_a), .fwd_valid(fv_a), .fwd_dest(fd_a), .fwd_value(fval_a),
    .occupancy(occ_a), .stall_cycles(sc_a));

  exe_mem_stage_buffer #(.XLEN(32), .REG_AW(5), .SKID_EN(0), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_pc(in_pc), .in_alu_result(in_alu_result), .in_st_val(in_st_val), .in_dest(in_dest),
    .in_mem_r_en(in_mem_r_en), .in_mem_w_en(in_mem_w_en), .in_wb_en(in_wb_en),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_pc(pc_b), .out_alu_result(alu_b),
    .out_st_val(st_b), .out_dest(dest_b), .out_mem_r_en(r_b), .out_mem_w_en(w_b),
    .out_wb_en(wb_b), .fwd_valid(fv_b), .fwd_dest(fd_b), .fwd_value(fval_b),
    .occupancy(occ_b), .stall_cycles(sc_b));

  int   n_tests = 0;
  int   n_fail  = 0;
  ent_t qa[$];
  ent_t qb[$];
  int   cnt_a = 0;
  int   cnt_b = 0;
  vec_t tbl[9];

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_side(string t, ent_t h, int size, int cnt, bit exp_rdy,
                            logic ov, logic [31:0] pc, logic [31:0] alu, logic [31:0] st,
                            logic [4:0] dest, logic r, logic w, logic wb, logic fv,
                            logic [4:0] fd, logic [31:0] fval, logic [1:0] occ,
                            logic ir, logic [15:0] sc);
    bit v;
    v = (size > 0);
    check({t, ".out_valid"}, ov, v);
    check({t, ".mem_r_en"}, r, v & h.r);
    check({t, ".mem_w_en"}, w, v & h.w);
    check({t, ".wb_en"}, wb, v & h.wb);
    check({t, ".fwd_valid"}, fv, v & h.wb & ~h.r);
    check({t, ".occupancy"}, occ, size);
    check({t, ".in_ready"}, ir, exp_rdy);
    check({t, ".stall_cycles"}, sc, cnt);
    if (v) begin
      check({t, ".out_pc"}, pc, h.pc);
      check({t, ".out_alu"}, alu, h.alu);
      check({t, ".out_st_val"}, st, h.st);
      check({t, ".out_dest"}, dest, h.dest);
      check({t, ".fwd_dest"}, fd, h.dest);
      check({t, ".fwd_value"}, fval, h.alu);
    end
  endtask

  task automatic check_all();
    ent_t ha, hb;
    ha = '0;
    hb = '0;
    if (qa.size() > 0) ha = qa[0];
    if (qb.size() > 0) hb = qb[0];
    check_side("a", ha, qa.size(), cnt_a, qa.size() < 2, out_valid_a, pc_a, alu_a, st_a,
               dest_a, r_a, w_a, wb_a, fv_a, fd_a, fval_a, occ_a, in_ready_a, 16'(sc_a));
    check_side("b", hb, qb.size(), cnt_b, (qb.size() == 0) || out_ready, out_valid_b, pc_b,
               alu_b, st_b, dest_b, r_b, w_b, wb_b, fv_b, fd_b, fval_b, occ_b, in_ready_b, sc_b);
  endtask

  // Called at a falling edge: drive, let one rising edge pass, update models, check.
  task automatic step(bit iv, ent_t e, bit orr, bit fl);
    bit acc_a, acc_b, pop_a, pop_b;
    in_valid  = iv;
    {in_pc, in_alu_result, in_st_val, in_dest, in_mem_r_en, in_mem_w_en, in_wb_en} = e;
    out_ready = orr;
    flush     = fl;
    acc_a = iv && (qa.size() < 2);
    acc_b = iv && ((qb.size() == 0) || orr);
    pop_a = (qa.size() > 0) && orr;
    pop_b = (qb.size() > 0) && orr;
    @(posedge clk);
    if (qa.size() > 0 && !orr && cnt_a < 15) cnt_a++;
    if (qb.size() > 0 && !orr && cnt_b < 65535) cnt_b++;
    if (fl) begin
      qa.delete();
      qb.delete();
    end else begin
      if (pop_a) void'(qa.pop_front());
      if (acc_a) qa.push_back(e);
      if (pop_b) void'(qb.pop_front());
      if (acc_b) qb.push_back(e);
    end
    @(negedge clk);
    check_all();
  endtask

  function automatic ent_t mk_e(logic [31:0] pc, logic [31:0] alu, logic [4:0] dest,
                                bit r, bit w, bit wb);
    ent_t e;
    e.pc = pc; e.alu = alu; e.st = pc ^ 32'hDEAD_0000; e.dest = dest;
    e.r = r; e.w = w; e.wb = wb;
    return e;
  endfunction

  function automatic vec_t mk(bit iv, ent_t e, bit orr, bit fl, int oa, bit ra, int ob);
    vec_t v;
    v.in_valid = iv; v.e = e; v.out_ready = orr; v.flush = fl;
    v.exp_occ_a = oa; v.exp_rdy_a = ra; v.exp_occ_b = ob;
    return v;
  endfunction

  initial begin
    ent_t e;
    tbl[0] = mk(1, mk_e(32'h100, 32'h5,  5'd3, 0, 0, 1), 1, 0, 1, 1, 1);
    tbl[1] = mk(1, mk_e(32'h104, 32'h6,  5'd4, 0, 1, 0), 0, 0, 2, 0, 1);
    tbl[2] = mk(1, mk_e(32'h108, 32'h7,  5'd5, 0, 0, 1), 0, 0, 2, 0, 1);
    tbl[3] = mk(0, mk_e(32'h0,   32'h0,  5'd0, 0, 0, 0), 1, 0, 1, 1, 0);
    tbl[4] = mk(1, mk_e(32'h10C, 32'h8,  5'd6, 0, 0, 1), 1, 0, 1, 1, 1);
    tbl[5] = mk(1, mk_e(32'h110, 32'h9,  5'd7, 1, 0, 1), 0, 0, 2, 0, 1);
    tbl[6] = mk(1, mk_e(32'h114, 32'hA,  5'd8, 0, 1, 1), 0, 1, 0, 1, 0);
    tbl[7] = mk(0, mk_e(32'h0,   32'h0,  5'd0, 0, 0, 0), 1, 0, 0, 1, 0);
    tbl[8] = mk(1, mk_e(32'h118, 32'hB,  5'd9, 1, 0, 1), 0, 0, 1, 1, 1);

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_all();
    check("reset.out_pc_a", pc_a, 0);
    check("reset.fwd_value_a", fval_a, 0);
    check("reset.out_dest_b", dest_b, 0);
    check("reset.out_st_b", st_b, 0);

    // Full-throughput streaming in both modes.
    for (int i = 0; i < 8; i++) begin
      step(1, mk_e(32'h200 + 32'(4 * i), 32'(i), 5'(i + 1), 0, 0, 1), 1, 0);
      check("stream.valid_a", out_valid_a, 1);
      check("stream.valid_b", out_valid_b, 1);
      check("stream.pc_a", pc_a, 32'h200 + 32'(4 * i));
      check("stream.pc_b", pc_b, 32'h200 + 32'(4 * i));
    end
    step(0, '0, 1, 0);
    check("stream.stall_a", sc_a, 0);
    check("stream.stall_b", sc_b, 0);

    // Directed table: first-beat latency, skid fill/drain, flush with in_valid.
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].in_valid, tbl[i].e, tbl[i].out_ready, tbl[i].flush);
      check($sformatf("tbl%0d.occ_a", i), occ_a, tbl[i].exp_occ_a);
      check($sformatf("tbl%0d.rdy_a", i), in_ready_a, tbl[i].exp_rdy_a);
      check($sformatf("tbl%0d.occ_b", i), occ_b, tbl[i].exp_occ_b);
      if (i == 0) begin
        check("t1.out_pc", pc_a, 32'h100);
        check("t1.fwd_valid", fv_a, 1);
        check("t1.fwd_dest", fd_a, 3);
        check("t1.fwd_value", fval_a, 5);
      end
      if (i == 6) begin
        check("flush.valid_a", out_valid_a, 0);
        check("flush.wb_a", wb_a, 0);
        check("flush.fwd_a", fv_a, 0);
      end
      if (i == 8) check("load.fwd_valid_a", fv_a, 0);
    end
    step(0, '0, 1, 0);

    // Randomised traffic against the queue models.
    for (int i = 0; i < 300; i++) begin
      e = mk_e($urandom, $urandom, 5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      step($urandom_range(0, 3) != 0, e, $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
    end

    // Saturation of the 4-bit counter under a long stall.
    step(1, mk_e(32'h300, 32'h1, 5'd1, 0, 0, 1), 0, 0);
    for (int i = 0; i < 20; i++) step(0, '0, 0, 0);
    check("sat.stall_a", sc_a, 15);
    check("sat.valid_a", out_valid_a, 1);

    // Asynchronous reset in the middle of a stall.
    #2 rst = 1'b1;
    #1;
    check("arst.valid_a", out_valid_a, 0);
    check("arst.valid_b", out_valid_b, 0);
    check("arst.rdy_a", in_ready_a, 1);
    check("arst.rdy_b", in_ready_b, 1);
    check("arst.occ_a", occ_a, 0);
    check("arst.stall_a", sc_a, 0);
    check("arst.stall_b", sc_b, 0);
    check("arst.pc_a", pc_a, 0);
    check("arst.wb_b", wb_b, 0);
    check("arst.fwd_a", fv_a, 0);
    qa.delete();
    qb.delete();
    cnt_a = 0;
    cnt_b = 0;
    @(negedge clk);
    rst = 1'b0;
    check_all();
    step(1, mk_e(32'h400, 32'h2, 5'd2, 0, 0, 1), 1, 0);
    step(0, '0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
